// File: rtl/mptw_req_scheduler_pkg.sv
// Shared types for the MPT walker front end: CSR image, access/fault codes and
// the transaction that travels down the walker pipeline.
package mptw_req_scheduler_pkg;

   localparam int MPTW_ID_WIDTH = 2;

   typedef enum logic [1:0] {
      ACCESS_READ    = 2'd0,
      ACCESS_WRITE   = 2'd1,
      ACCESS_EXECUTE = 2'd2
   } access_type_e;

   typedef enum logic [1:0] {
      NO_ERROR             = 2'd0,
      FORMAT_RESERVED_BITS = 2'd1,
      FORMAT_INVALID_MODE  = 2'd2,
      FORMAT_MISALIGNED    = 2'd3
   } page_format_fault_e;

   typedef enum logic [1:0] {
      MPT_WALKING_IDLE = 2'd0,
      MPT_WALKING_DO   = 2'd1,
      MPT_WALKING_DONE = 2'd2
   } mpt_walking_e;

   typedef struct packed {
      logic [3:0]  mode;
      logic [15:0] sdid;
      logic [43:0] ppn;
   } mmpt_reg_t;

   typedef struct packed {
      logic                     valid;
      logic                     completed;
      mpt_walking_e             walking;
      logic [MPTW_ID_WIDTH-1:0] id;
      mmpt_reg_t                mmpt;
      logic [63:0]              spa;
      access_type_e             access_type;
      page_format_fault_e       format_error;
      logic                     access_error;
      logic [63:0]              mpte;
      logic                     plb_hit;
   } mptw_transaction_t;

endpackage

// File: rtl/mptw_req_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first valid at or after ptr_i, cyclically.
// Combinational; the caller owns the pointer so it only advances on a real handshake.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         valid_i,
   input  logic                 en_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   output logic [N-1:0]         grant_o,
   output logic [$clog2(N)-1:0] idx_o
);

   localparam int IW = $clog2(N);

   int          k;
   logic [IW-1:0] kc;

   // Scan from the farthest offset down so the nearest valid wins last.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      k       = 0;
      kc      = '0;
      for (int off = N - 1; off >= 0; off--) begin
         k = int'(ptr_i) + off;
         if (k >= N) k = k - N;
         kc = IW'(k);
         if (en_i && valid_i[kc]) begin
            grant_o     = '0;
            grant_o[kc] = 1'b1;
            idx_o       = kc;
         end
      end
   end

endmodule

// File: rtl/mptw_req_scheduler.sv
// Walker front end: round-robin request arbitration, transaction ID allocation,
// a registered pipeline master port and completion routing back to the ID owner.
module mptw_req_scheduler
   import mptw_req_scheduler_pkg::*;
#(
   parameter int NUM_REQ             = 4,
   parameter int ID_WIDTH            = MPTW_ID_WIDTH,
   parameter int PIPELINE_DATA_WIDTH = $bits(mptw_transaction_t)
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  mmpt_reg_t                          mmpt_i,
   input  logic [NUM_REQ-1:0]                 req_valid_i,
   output logic [NUM_REQ-1:0]                 req_ready_o,
   input  logic [NUM_REQ-1:0][63:0]           req_spa_i,
   input  access_type_e [NUM_REQ-1:0]         req_access_type_i,
   output logic                               pipe_valid_o,
   input  logic                               pipe_ready_i,
   output logic [PIPELINE_DATA_WIDTH-1:0]     pipe_data_o,
   input  logic                               cmp_valid_i,
   output logic                               cmp_ready_o,
   input  logic [ID_WIDTH-1:0]                cmp_id_i,
   input  page_format_fault_e                 cmp_format_error_i,
   input  logic                               cmp_access_error_i,
   output logic [NUM_REQ-1:0]                 rsp_valid_o,
   input  logic [NUM_REQ-1:0]                 rsp_ready_i,
   output page_format_fault_e                 rsp_format_error_o,
   output logic                               rsp_access_error_o,
   output logic [ID_WIDTH:0]                  outstanding_o,
   output logic                               err_spurious_o
);

   localparam int MAX_OUT = 2 ** ID_WIDTH;
   localparam int REQ_W   = $clog2(NUM_REQ);

   // Every port uses valid/ready: a transfer happens on a clock edge where both are
   // high; a source holds valid and its payload until that edge, ready may depend on valid.

   logic [MAX_OUT-1:0]            free_q, free_d, alloc_mask, release_mask;
   logic [MAX_OUT-1:0][REQ_W-1:0] owner_q;
   logic [REQ_W-1:0]              rr_ptr_q, grant_idx, cmp_owner;
   logic [NUM_REQ-1:0]            grant;
   logic [ID_WIDTH-1:0]           alloc_id;
   logic [ID_WIDTH:0]             outstanding_d;
   logic                          can_issue, req_hs, cmp_spurious, cmp_hs;
   logic                          pipe_valid_q;
   mptw_transaction_t             pipe_data_q, tx;

   assign can_issue = (|free_q) && (!pipe_valid_q || pipe_ready_i);

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .valid_i (req_valid_i),
      .en_i    (can_issue),
      .ptr_i   (rr_ptr_q),
      .grant_o (grant),
      .idx_o   (grant_idx)
   );

   assign req_ready_o = grant;
   assign req_hs      = |grant;

   always_comb begin
      alloc_id = '0;
      for (int i = MAX_OUT - 1; i >= 0; i--) begin
         if (free_q[i]) alloc_id = ID_WIDTH'(i);
      end
   end

   // A completion for a free ID is swallowed: accepted, not routed, flagged.
   assign cmp_owner          = owner_q[cmp_id_i];
   assign cmp_spurious       = cmp_valid_i && free_q[cmp_id_i];
   assign cmp_ready_o        = cmp_spurious || rsp_ready_i[cmp_owner];
   assign cmp_hs             = cmp_valid_i && cmp_ready_o && !cmp_spurious;
   assign rsp_valid_o        = (cmp_valid_i && !cmp_spurious) ? (NUM_REQ'(1) << cmp_owner) : '0;
   assign rsp_format_error_o = cmp_format_error_i;
   assign rsp_access_error_o = cmp_access_error_i;

   assign alloc_mask   = req_hs ? (MAX_OUT'(1) << alloc_id) : '0;
   assign release_mask = cmp_hs ? (MAX_OUT'(1) << cmp_id_i) : '0;
   assign free_d       = (free_q & ~alloc_mask) | release_mask;

   always_comb begin
      outstanding_d = '0;
      for (int i = 0; i < MAX_OUT; i++) begin
         if (!free_d[i]) outstanding_d = outstanding_d + (ID_WIDTH + 1)'(1);
      end
   end

   always_comb begin
      tx              = '0;
      tx.valid        = 1'b1;
      tx.walking      = MPT_WALKING_DO;
      tx.format_error = NO_ERROR;
      tx.id           = MPTW_ID_WIDTH'(alloc_id);
      tx.mmpt         = mmpt_i;
      tx.spa          = req_spa_i[grant_idx];
      tx.access_type  = req_access_type_i[grant_idx];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         free_q         <= '1;
         owner_q        <= '0;
         rr_ptr_q       <= '0;
         outstanding_o  <= '0;
         err_spurious_o <= 1'b0;
         pipe_valid_q   <= 1'b0;
         pipe_data_q    <= '0;
      end else begin
         free_q        <= free_d;
         outstanding_o <= outstanding_d;
         if (cmp_spurious) err_spurious_o <= 1'b1;
         // A grant reloads the output register even while it drains, for 1/cycle throughput.
         if (req_hs) begin
            owner_q[alloc_id] <= grant_idx;
            rr_ptr_q          <= (grant_idx == REQ_W'(NUM_REQ - 1)) ? '0 : grant_idx + REQ_W'(1);
            pipe_valid_q      <= 1'b1;
            pipe_data_q       <= tx;
         end else if (pipe_ready_i) begin
            pipe_valid_q <= 1'b0;
         end
      end
   end

   assign pipe_valid_o = pipe_valid_q;
   assign pipe_data_o  = pipe_data_q;

endmodule
